// File: rtl/spi_xfer_queue.sv
// spi_xfer_queue: queues TX words and runs one spi_core character per word (TX_0, CTRL+GO, intr, RX_0).
// Latency: 5 cycles of register traffic plus SPI transfer time per word, RX word visible the cycle after capture.
// Backpressure: cmd_ready_o low while TX FIFO full; a word starts only once an RX slot is free. Macro: SPI_XQ_TIMEOUT_EN.

// spi_xq_fifo: generic power-of-2 FIFO with occupancy count.
// Latency: push visible at dat_o the next cycle; dat_o reads 0 while empty.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module spi_xq_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             dat_i,
    output logic [W-1:0]             dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop  = pop_i && (cnt_q != '0);
        do_push = push_i && ((cnt_q != FULL_CNT) || do_pop);
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
        cnt_d   = cnt_q;
        if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
        if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= dat_i;
    end

    assign dat_o   = (cnt_q != '0) ? mem_q[rd_q] : '0;
    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;
endmodule

module spi_xfer_queue #(
    parameter int          CMD_DEPTH   = 4,
    parameter int          RSP_DEPTH   = 4,
    parameter logic [7:0]  ADDR_TX0    = 8'h00,
    parameter logic [7:0]  ADDR_RX0    = 8'h00,
    parameter logic [7:0]  ADDR_CTRL   = 8'h10,
    parameter logic [31:0] CTRL_CFG    = 32'h1008,
    parameter int          GO_BIT      = 8,
    parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    output logic [7:0]  core_addr_o,
    output logic [31:0] core_wdata_o,
    output logic [3:0]  core_be_o,
    output logic        core_we_o,
    output logic        core_re_o,
    input  logic [31:0] core_rdata_i,
    input  logic        core_intr_i
);
    typedef enum logic [2:0] {
        S_IDLE, S_WR_TX, S_WR_CTRL, S_WAIT, S_RD_REQ, S_RD_CAP
    } state_e;

    localparam int RAW = $clog2(RSP_DEPTH);
    localparam logic [RAW:0] RSP_FULL = (RAW+1)'(RSP_DEPTH);

    state_e state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d, re_q, re_d;

    logic [31:0]              tx_dat;
    logic                     tx_push, tx_pop, tx_full, tx_empty;
    logic [$clog2(CMD_DEPTH):0] tx_cnt_unused;
    logic [32:0]              rx_din, rx_dout;
    logic                     rx_push, rx_empty, rx_full_unused;
    logic [RAW:0]             rx_cnt;

`ifdef SPI_XQ_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYC;
`endif

    // Registered strobes are computed from the next state, so they are high while in that state.
    always_comb begin
        state_d = state_q;
        addr_d  = '0;
        wdata_d = '0;
        be_d    = '0;
        we_d    = 1'b0;
        re_d    = 1'b0;
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        rx_din  = '0;
`ifdef SPI_XQ_TIMEOUT_EN
        wd_d    = wd_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (!tx_empty && (rx_cnt != RSP_FULL)) begin
                    state_d = S_WR_TX;
                    tx_pop  = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = ADDR_TX0;
                    wdata_d = tx_dat;
                    be_d    = 4'hF;
                end
            end
            S_WR_TX: begin
                state_d = S_WR_CTRL;
                we_d    = 1'b1;
                addr_d  = ADDR_CTRL;
                wdata_d = CTRL_CFG | (32'd1 << GO_BIT);
                be_d    = 4'h3;
            end
            S_WR_CTRL: begin
                state_d = S_WAIT;
`ifdef SPI_XQ_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            S_WAIT: begin
                if (core_intr_i) begin
                    state_d = S_RD_REQ;
                    re_d    = 1'b1;
                    addr_d  = ADDR_RX0;
                end
`ifdef SPI_XQ_TIMEOUT_EN
                // Abort with an error word; the core's GO bit is left for software to clear.
                else if (wd_q == TIMEOUT_CYC - 16'd1) begin
                    state_d = S_IDLE;
                    rx_push = 1'b1;
                    rx_din  = {1'b1, 32'h0};
                end else begin
                    wd_d = wd_q + 16'd1;
                end
`endif
            end
            S_RD_REQ: state_d = S_RD_CAP;
            S_RD_CAP: begin
                state_d = S_IDLE;
                rx_push = 1'b1;
                rx_din  = {1'b0, core_rdata_i};
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            re_q    <= re_d;
        end
    end

`ifdef SPI_XQ_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) wd_q <= '0;
        else         wd_q <= wd_d;
    end
`endif

    // A full TX FIFO still accepts a word in the cycle its head is popped.
    assign cmd_ready_o = !tx_full || tx_pop;
    assign tx_push     = cmd_valid_i && cmd_ready_o;

    spi_xq_fifo #(.W(32), .DEPTH(CMD_DEPTH)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .dat_i   (cmd_data_i),
        .dat_o   (tx_dat),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .cnt_o   (tx_cnt_unused)
    );

    spi_xq_fifo #(.W(33), .DEPTH(RSP_DEPTH)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (rx_push),
        .pop_i   (rsp_ready_i),
        .dat_i   (rx_din),
        .dat_o   (rx_dout),
        .full_o  (rx_full_unused),
        .empty_o (rx_empty),
        .cnt_o   (rx_cnt)
    );

    assign rsp_valid_o  = !rx_empty;
    assign rsp_data_o   = rx_dout[31:0];
`ifdef SPI_XQ_TIMEOUT_EN
    assign rsp_err_o    = rx_dout[32];
`else
    assign rsp_err_o    = 1'b0;
`endif
    assign busy_o       = (state_q != S_IDLE) || !tx_empty;
    assign core_addr_o  = addr_q;
    assign core_wdata_o = wdata_q;
    assign core_be_o    = be_q;
    assign core_we_o    = we_q;
    assign core_re_o    = re_q;
endmodule
